// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button event decoder.
// BTN_DOUBLE_CLICK_EN (see btn_event_decoder) selects whether the double-click states are built.
package btn_pkg;

  localparam int unsigned LONG_CNT_DEF = 100_000_000;
  localparam int unsigned DBL_CNT_DEF  = 15_000_000;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRESSED     = 3'd1,
    S_LONG_HELD   = 3'd2,
    S_WAIT_2ND    = 3'd3,
    S_PRESSED_2ND = 3'd4
  } btn_state_t;

  // One spare bit above the larger terminal count keeps the counter from wrapping.
  function automatic int cnt_width(input int unsigned a, input int unsigned b);
    return (a > b) ? ($clog2(a) + 1) : ($clog2(b) + 1);
  endfunction

endpackage

// File: rtl/pb_edge_det.sv
// Registers the debounced button level and derives single-cycle rise/fall strobes.
module pb_edge_det (
  input  logic clk,
  input  logic arst,
  input  logic level,
  output logic rise,
  output logic fall,
  output logic level_q
);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button into press, short, long and double-click events.
// Define BTN_DOUBLE_CLICK_EN to build the double-click states; otherwise a release ends in a short press.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CNT = LONG_CNT_DEF,
  parameter int unsigned DBL_CNT  = DBL_CNT_DEF
) (
  input  logic clk,
  input  logic arst,
  input  logic pb_stbl,
  output logic press_p,
  output logic short_p,
  output logic long_p,
  output logic dbl_p,
  output logic held
);

  localparam int CNT_W = cnt_width(LONG_CNT, DBL_CNT);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  localparam logic [2:0] IDLE      = S_IDLE;
  localparam logic [2:0] PRESSED   = S_PRESSED;
  localparam logic [2:0] LONG_HELD = S_LONG_HELD;
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] DBL_LAST = CNT_W'(DBL_CNT - 1);
  localparam logic [2:0] WAIT_2ND    = S_WAIT_2ND;
  localparam logic [2:0] PRESSED_2ND = S_PRESSED_2ND;
`endif

  logic             rise;
  logic             fall;
  logic             pb_d;
  logic             hold_on;
  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             press_nx;
  logic             short_nx;
  logic             long_nx;
`ifdef BTN_DOUBLE_CLICK_EN
  logic             dbl_nx;
`endif

  pb_edge_det u_edge (
    .clk     (clk),
    .arst    (arst),
    .level   (pb_stbl),
    .rise    (rise),
    .fall    (fall),
    .level_q (pb_d)
  );

  assign hold_on = pb_stbl & pb_d;

  // A fall always takes priority over a terminal count, and a rise over the double-click timeout.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press_nx = 1'b0;
    short_nx = 1'b0;
    long_nx  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
    dbl_nx   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          cnt_nx = '0;
`ifdef BTN_DOUBLE_CLICK_EN
          state_nx = WAIT_2ND;
`else
          state_nx = IDLE;
          short_nx = 1'b1;
`endif
        end else if (hold_on && (cnt == LONG_LAST)) begin
          state_nx = LONG_HELD;
          cnt_nx   = '0;
          long_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_nx = IDLE;
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      WAIT_2ND: begin
        if (rise) begin
          state_nx = PRESSED_2ND;
          cnt_nx   = '0;
          press_nx = 1'b1;
          dbl_nx   = 1'b1;
        end else if (cnt == DBL_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          short_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED_2ND: begin
        if (fall) begin
          state_nx = IDLE;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      cnt     <= '0;
      press_p <= 1'b0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      held    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      press_p <= press_nx;
      short_p <= short_nx;
      long_p  <= long_nx;
      held    <= (state_nx == LONG_HELD);
    end
  end

`ifdef BTN_DOUBLE_CLICK_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      dbl_p <= 1'b0;
    end else begin
      dbl_p <= dbl_nx;
    end
  end
`else
  assign dbl_p = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with LONG_CNT=8, DBL_CNT=4; follows BTN_DOUBLE_CLICK_EN when defined.
module tb_btn_event_decoder;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] D = 5'b00010;
  localparam logic [4:0] H = 5'b00001;

  typedef struct {
    logic       pb;
    logic [4:0] exp;
    string      tag;
  } vec_t;

  logic clk;
  logic arst;
  logic pb_stbl;
  logic press_p;
  logic short_p;
  logic long_p;
  logic dbl_p;
  logic held;

  int   tests_run;
  int   tests_failed;
  vec_t vecs[$];

  btn_event_decoder #(
    .LONG_CNT (8),
    .DBL_CNT  (4)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .pb_stbl (pb_stbl),
    .press_p (press_p),
    .short_p (short_p),
    .long_p  (long_p),
    .dbl_p   (dbl_p),
    .held    (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_vec(input logic pb, input logic [4:0] exp, input string tag);
    vecs.push_back('{pb: pb, exp: exp, tag: tag});
  endfunction

  // Drive the level on the falling edge so the DUT sees it at the next rising edge.
  task automatic applyStimulus(input logic pb);
    @(negedge clk);
    pb_stbl = pb;
    @(posedge clk);
    #1;
  endtask

  // Output order is {press_p, short_p, long_p, dbl_p, held}.
  task automatic checkOutput(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {press_p, short_p, long_p, dbl_p, held};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b (press,short,long,dbl,held)", name, act, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    arst         = 1'b1;
    pb_stbl      = 1'b0;

    // Short press: 3 high, then low
    add_vec(1'b1, P, "A_press");
    add_vec(1'b1, N, "A_hold");
    add_vec(1'b1, N, "A_hold");
`ifdef BTN_DOUBLE_CLICK_EN
    for (int i = 0; i < 6; i++) add_vec(1'b0, (i == 4) ? S : N, "A_wait");
`else
    add_vec(1'b0, S, "A_fall");
    for (int i = 0; i < 5; i++) add_vec(1'b0, N, "A_idle");
`endif

    // Long press: 12 high, then low
    add_vec(1'b1, P, "B_press");
    for (int i = 0; i < 7; i++) add_vec(1'b1, N, "B_count");
    add_vec(1'b1, L | H, "B_long");
    for (int i = 0; i < 3; i++) add_vec(1'b1, H, "B_held");
    add_vec(1'b0, N, "B_release");
    add_vec(1'b0, N, "B_idle");

    // Press 2, release 2, press 2, release
    add_vec(1'b1, P, "C_press1");
    add_vec(1'b1, N, "C_hold1");
`ifdef BTN_DOUBLE_CLICK_EN
    add_vec(1'b0, N, "C_fall1");
    add_vec(1'b0, N, "C_gap");
    add_vec(1'b1, P | D, "C_press2");
    add_vec(1'b1, N, "C_hold2");
    add_vec(1'b0, N, "C_fall2");
`else
    add_vec(1'b0, S, "C_fall1");
    add_vec(1'b0, N, "C_gap");
    add_vec(1'b1, P, "C_press2");
    add_vec(1'b1, N, "C_hold2");
    add_vec(1'b0, S, "C_fall2");
`endif
    for (int i = 0; i < 5; i++) add_vec(1'b0, N, "C_idle");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", N);
    @(negedge clk);
    arst = 1'b0;
    repeat (2) applyStimulus(1'b0);
    checkOutput("idle_after_reset", N);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pb);
      checkOutput(vecs[i].tag, vecs[i].exp);
    end

    // Fall on the LONG_CNT-1 cycle, then second rise on the DBL_CNT-1 cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1);
      checkOutput("D_hold", (i == 0) ? P : N);
    end
    applyStimulus(1'b0);
`ifdef BTN_DOUBLE_CLICK_EN
    checkOutput("D_fall_at_long_last", N);
`else
    checkOutput("D_fall_at_long_last", S);
`endif
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0);
      checkOutput("D_gap", N);
    end
    applyStimulus(1'b1);
`ifdef BTN_DOUBLE_CLICK_EN
    checkOutput("D_rise_at_dbl_last", P | D);
    applyStimulus(1'b0);
    checkOutput("D_fall2", N);
`else
    checkOutput("D_rise_at_dbl_last", P);
    applyStimulus(1'b0);
    checkOutput("D_fall2", S);
`endif
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0);
      checkOutput("D_idle", N);
    end

    // Asynchronous reset while pressed, then re-press with the button still down
    applyStimulus(1'b1);
    checkOutput("E_press", P);
    #2;
    arst = 1'b1;
    #1;
    checkOutput("E_async_clear", N);
    @(posedge clk);
    #1;
    checkOutput("E_in_reset", N);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("E_repress", P);
    applyStimulus(1'b0);
`ifdef BTN_DOUBLE_CLICK_EN
    checkOutput("E_fall", N);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      checkOutput("E_wait", (i == 3) ? S : N);
    end
`else
    checkOutput("E_fall", S);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      checkOutput("E_wait", N);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/btn_event_decoder.md
BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

Interface
REQ-001 LONG_CNT, default 100_000_000, clk cycles a press must be held to count as a long press (≥2).
REQ-002 DBL_CNT, default 15_000_000, clk cycles after a release during which a second press makes a double click (≥2).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 arst  input  1  asynchronous, active-high reset.
REQ-005 pb_stbl  input  1  debounced button level from the debounce stage, synchronous to clk, 1 = pressed.
REQ-006 press_p  output  1  one-cycle pulse on every press (rising edge of pb_stbl).
REQ-007 short_p  output  1  one-cycle pulse for a completed short press.
REQ-008 long_p  output  1  one-cycle pulse when a hold reaches LONG_CNT.
REQ-009 dbl_p  output  1  one-cycle pulse for a double click.
REQ-010 held  output  1  level, high while in LONG_HELD.

Function
REQ-011 The block SHALL register pb_stbl into pb_d; rise = pb_stbl & ~pb_d, fall = ~pb_stbl & pb_d.
REQ-012 All outputs SHALL be registered; each pulse is high exactly one cycle, in the cycle after the triggering edge/count is sampled.
REQ-013 States: IDLE, PRESSED, LONG_HELD, WAIT_2ND, PRESSED_2ND.
REQ-014 IDLE: rise -> PRESSED, cnt <= 0, press_p pulse.
REQ-015 PRESSED: cnt increments each cycle; cnt == LONG_CNT-1 with pb_stbl high -> LONG_HELD with long_p pulse; fall before that -> WAIT_2ND with cnt <= 0.
REQ-016 Fall and cnt == LONG_CNT-1 in the same cycle: fall wins, no long_p.
REQ-017 LONG_HELD: held = 1; fall -> IDLE; no short_p or dbl_p from this press.
REQ-018 WAIT_2ND: cnt increments; rise -> PRESSED_2ND with press_p and dbl_p pulses; cnt == DBL_CNT-1 with no rise -> IDLE with short_p pulse.
REQ-019 Rise and cnt == DBL_CNT-1 in the same cycle: rise wins (double click).
REQ-020 PRESSED_2ND: no counting, no long_p; fall -> IDLE.
REQ-021 cnt width = $clog2(max(LONG_CNT, DBL_CNT)) + 1; cnt never wraps because the state always exits at its terminal value.
REQ-022 Events are mutually exclusive: at most one of short_p/long_p/dbl_p per cycle.
REQ-023 An illegal state encoding SHALL return to IDLE on the next clock with all outputs low.

Reset
REQ-024 arst high SHALL asynchronously force state = IDLE, cnt = 0, pb_d = 0, and all outputs to 0.
REQ-025 Reset mid-press: after release of arst with pb_stbl already high, pb_d = 0 makes the next cycle a rise, so a fresh press_p is issued.

Configuration
REQ-026 Macro BTN_DOUBLE_CLICK_EN defined: behaviour as above.
REQ-027 Macro not defined: WAIT_2ND and PRESSED_2ND are removed, dbl_p is tied to 0, and a fall in PRESSED goes to IDLE with a short_p pulse in the cycle after the fall (DBL_CNT unused).

Structure
REQ-028 Shared package btn_pkg SHALL hold the state enum type btn_state_t and the default LONG_CNT/DBL_CNT constants.
REQ-029 Edge detection SHALL be a sub-module pb_edge_det (inputs clk, arst, level; outputs rise, fall, registered level).

Verification (LONG_CNT=8, DBL_CNT=4, macro defined unless stated)
REQ-030 pb_stbl high 3 cycles, then low for 6 -> one press_p; short_p exactly 4 cycles after the fall is sampled; no long_p or dbl_p.
REQ-031 pb_stbl held high 12 cycles -> press_p, then long_p 8 cycles later, held high until 1 cycle after the fall; no short_p.
REQ-032 Press 2, release 2, press 2, release -> two press_p, one dbl_p coincident with the second press_p, no short_p.
REQ-033 Second rise lands exactly on the DBL_CNT-1 cycle -> dbl_p, no short_p; fall lands on the LONG_CNT-1 cycle -> no long_p.
REQ-034 arst pulsed while in PRESSED with pb_stbl high -> outputs 0 immediately; after release, a new press_p follows.
REQ-035 Macro undefined: press 2 / release -> short_p 1 cycle after the fall; second press -> press_p only, dbl_p stays 0.
